// File: rtl/pio_in_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_in_edge_pkg
// Description : Shared constants and helpers for the edge-capturing input PIO.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_in_edge_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pio_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : pio_debounce_bit
// Description : One input channel: synchroniser, debounce filter, edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_debounce_bit
    import pio_in_edge_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    logic                   w_raw;
    logic                   w_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign w_raw = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_filter
            localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;

            // Counter restarts whenever the input agrees with the accepted level,
            // so only an uninterrupted disagreement can reach CNT_LAST.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if ((w_raw == r_stable) || w_take) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_take = (w_raw != r_stable) && (r_cnt == CNT_LAST);
        end else begin : g_bypass
            assign w_take = (w_raw != r_stable);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= 1'b0;
        end else if (w_take) begin
            r_stable <= w_raw;
        end
    end

    assign o_raw    = w_raw;
    assign o_stable = r_stable;
    assign o_rise   = w_take & w_raw;
    assign o_fall   = w_take & ~w_raw;

endmodule
`default_nettype wire

// File: rtl/pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : pio_in_edge_irq
// Description : Avalon-MM debounced input PIO with W1C edge capture and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_in_edge_irq
    import pio_in_edge_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0,
    parameter int IRQ_EN          = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            pio_debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_bit (
                .clk      (clk),
                .reset    (reset),
                .i_pin    (in_port[gi]),
                .o_raw    (w_raw[gi]),
                .o_stable (w_stable[gi]),
                .o_rise   (w_rise[gi]),
                .o_fall   (w_fall[gi])
            );
        end
    endgenerate

    always_comb begin
        w_set = '0;
        case (EDGE_MODE)
            EDGE_RISE: w_set = w_rise;
            EDGE_FALL: w_set = w_fall;
            default:   w_set = w_rise | w_fall;
        endcase
    end

    assign w_w1c          = (write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = ^writedata;

    // New edges win over a simultaneous software clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_w1c) | w_set;
        end
    end

    generate
        if (IRQ_EN != 0) begin : g_irq
            logic [WIDTH-1:0] r_mask;
            logic             r_irq;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_mask <= '0;
                    r_irq  <= 1'b0;
                end else begin
                    if (write && (address == ADDR_MASK)) begin
                        r_mask <= writedata[WIDTH-1:0];
                    end
                    r_irq <= |(r_edge_cap & r_mask);
                end
            end

            assign w_irq_mask = r_mask;
            assign irq        = r_irq;
        end else begin : g_no_irq
            assign w_irq_mask = '0;
            assign irq        = 1'b0;
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA: w_rdata[WIDTH-1:0] = w_stable;
            ADDR_RAW:  w_rdata[WIDTH-1:0] = w_raw;
            ADDR_MASK: w_rdata[WIDTH-1:0] = w_irq_mask;
            default:   w_rdata[WIDTH-1:0] = r_edge_cap;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_in_edge_irq
// Description : Bench for pio_in_edge_irq: rising-mode and falling-mode builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_in_edge_irq;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int DC = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  addr  [2];
    logic        wr    [2];
    logic [31:0] wd    [2];
    logic [W-1:0] inp  [2];
    logic [31:0] rdata [2];
    logic        irq_o [2];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gd = 0; gd < 2; gd++) begin : g_dut
            // Build 0 captures rising edges, build 1 falling edges.
            pio_in_edge_irq #(
                .WIDTH           (W),
                .SYNC_STAGES     (SS),
                .DEBOUNCE_CYCLES (DC),
                .EDGE_MODE       (gd),
                .IRQ_EN          (1)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .address   (addr[gd]),
                .write     (wr[gd]),
                .writedata (wd[gd]),
                .readdata  (rdata[gd]),
                .in_port   (inp[gd]),
                .irq       (irq_o[gd])
            );

            // Model: pins pass through a SS-deep delay line; a level is accepted
            // once the last DC delayed samples all disagree with the accepted level.
            logic [W-1:0] inq [$];
            logic [W-1:0] shq [$];
            logic [W-1:0] m_stable, m_cap, m_mask, m_raw;
            logic [31:0]  m_rd;
            logic         m_irq;
            bit           m_valid = 0;

            always @(posedge clk) begin
                logic [W-1:0] pre_st, pre_cap, pre_mask, set, clr;
                bit all_diff;
                pre_st   = m_stable;
                pre_cap  = m_cap;
                pre_mask = m_mask;
                if (reset) begin
                    inq = {};
                    for (int k = 0; k < SS; k++) inq.push_back('0);
                    shq = {};
                    m_stable = '0; m_cap = '0; m_mask = '0; m_raw = '0;
                    m_rd = '0; m_irq = 1'b0; m_valid = 1;
                end else begin
                    case (addr[gd])
                        2'd0:    m_rd = 32'(pre_st);
                        2'd1:    m_rd = 32'(m_raw);
                        2'd2:    m_rd = 32'(pre_mask);
                        default: m_rd = 32'(pre_cap);
                    endcase
                    m_irq = |(pre_cap & pre_mask);
                    shq.push_back(m_raw);
                    set = '0;
                    for (int b = 0; b < W; b++) begin
                        if (shq.size() >= DC) begin
                            all_diff = 1;
                            for (int k = 1; k <= DC; k++)
                                if (shq[shq.size()-k][b] == pre_st[b]) all_diff = 0;
                            if (all_diff) begin
                                m_stable[b] = ~pre_st[b];
                                if ((gd == 0 && m_stable[b]) || (gd == 1 && !m_stable[b]))
                                    set[b] = 1'b1;
                            end
                        end
                    end
                    clr = (wr[gd] && addr[gd] == 2'd3) ? wd[gd][W-1:0] : '0;
                    m_cap = (pre_cap & ~clr) | set;
                    if (wr[gd] && addr[gd] == 2'd2) m_mask = wd[gd][W-1:0];
                    inq.push_back(inp[gd]);
                    m_raw = inq[inq.size()-SS];
                    while (inq.size() > SS) void'(inq.pop_front());
                    while (shq.size() > DC) void'(shq.pop_front());
                end
            end

            always @(posedge clk) begin
                #1;
                if (m_valid) begin
                    checks++;
                    if (rdata[gd] !== m_rd) begin
                        failures++;
                        $display("FAIL model_readdata[%0d] t=%0t actual=0x%08h required=0x%08h",
                                 gd, $time, rdata[gd], m_rd);
                    end
                    checks++;
                    if (irq_o[gd] !== m_irq) begin
                        failures++;
                        $display("FAIL model_irq[%0d] t=%0t actual=%0b required=%0b",
                                 gd, $time, irq_o[gd], m_irq);
                    end
                end
            end
        end
    endgenerate

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%08h required=0x%08h", nm, $time, act, exp);
        end
    endtask

    task automatic wr_reg(input int d, input logic [1:0] a, input logic [31:0] v);
        addr[d] = a;
        wd[d]   = v;
        wr[d]   = 1'b1;
        tick(1);
        wr[d]   = 1'b0;
    endtask

    task automatic rd_chk(input int d, input logic [1:0] a, input logic [31:0] exp, input string nm);
        addr[d] = a;
        tick(1);
        chk(nm, rdata[d], exp);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            addr[d] = 2'd0; wr[d] = 1'b0; wd[d] = '0; inp[d] = '0;
        end
        tick(3);
        reset = 1'b0;

        // Reset state of every register
        for (int a = 0; a < 4; a++) begin
            rd_chk(0, 2'(a), 32'h0, "reset_read");
            chk("reset_irq", 32'(irq_o[0]), 32'h0);
        end

        // Clean rising change: RAW after the sync chain, DATA after full latency
        addr[0] = 2'd0;
        addr[1] = 2'd1;
        tick(2);
        inp[0] = 4'h1;
        inp[1] = 4'h1;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            chk("data_latency", rdata[0], (k == 7) ? 32'h1 : 32'h0);
            if (k == 2) chk("raw_early", rdata[1], 32'h0);
            if (k == 3) chk("raw_valid", rdata[1], 32'h1);
        end
        rd_chk(0, 2'd3, 32'h1, "edge_cap_bit0");
        chk("irq_masked", 32'(irq_o[0]), 32'h0);
        wr_reg(0, 2'd3, 32'h1);

        // Short glitch is rejected, full-length pulse is accepted
        inp[0] = 4'h5; tick(3); inp[0] = 4'h1; tick(10);
        rd_chk(0, 2'd0, 32'h1, "glitch_data");
        rd_chk(0, 2'd3, 32'h0, "glitch_edge");
        inp[0] = 4'h5; tick(4); inp[0] = 4'h1; tick(12);
        rd_chk(0, 2'd3, 32'h4, "pulse_edge");

        // Mask exposes the pending edge, then W1C removes it
        wr_reg(0, 2'd2, 32'h4);
        chk("irq_before", 32'(irq_o[0]), 32'h0);
        tick(1);
        chk("irq_rise", 32'(irq_o[0]), 32'h1);
        wr_reg(0, 2'd3, 32'h4);
        chk("irq_hold", 32'(irq_o[0]), 32'h1);
        tick(1);
        chk("irq_fall", 32'(irq_o[0]), 32'h0);
        rd_chk(0, 2'd3, 32'h0, "edge_cleared");

        // W1C on the same edge that bit0 stable rises: set wins
        inp[0] = 4'h0; tick(10);
        inp[0] = 4'h1; tick(5);
        wr_reg(0, 2'd3, 32'h1);
        rd_chk(0, 2'd3, 32'h1, "set_priority");

        // Falling-mode build: rise ignored, fall captured
        inp[1] = 4'h9; tick(10);
        rd_chk(1, 2'd3, 32'h0, "fall_mode_rise");
        inp[1] = 4'h1; tick(10);
        rd_chk(1, 2'd3, 32'h8, "fall_mode_fall");
        wr_reg(1, 2'd2, 32'hF);
        tick(2);
        chk("fall_mode_irq", 32'(irq_o[1]), 32'h1);

        // Reset in the middle of a debounce interval
        inp[1] = 4'h0; tick(4);
        reset = 1'b1; tick(1); reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd_chk(1, 2'(a), 32'h0, "mid_reset_read");
            chk("mid_reset_irq", 32'(irq_o[1]), 32'h0);
        end
        tick(12);
        rd_chk(1, 2'd0, 32'h0, "mid_reset_data");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
